// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and helpers for the 4x4 hex keypad scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_class_e;

    // Number of keys seen closed in one 16-bit frame.
    function automatic logic [4:0] popcount16(input logic [15:0] f);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, f[i]};
        end
        return n;
    endfunction

    // Position of the lowest set bit; only meaningful for SINGLE frames.
    function automatic logic [3:0] index16(input logic [15:0] f);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (f[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic frame_class_e classify(input logic [15:0] f);
        logic [4:0] n;
        n = popcount16(f);
        if (n == 5'd0) begin
            return EMPTY;
        end else if (n == 5'd1) begin
            return SINGLE;
        end
        return MULTI;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_debounce
//  Description : Scan-level debounce FSM, key encoder and valid/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_frame,
    input  logic        i_scan_done,
    input  logic        i_key_ack,
    output logic [3:0]  o_key_code,
    output logic        o_key_valid,
    output logic        o_key_down,
    output logic        o_overrun
);

    // Wide enough to hold DEBOUNCE_SCANS+1 so the increment compare never wraps.
    localparam int              DC_W       = $clog2(DEBOUNCE_SCANS + 2);
    localparam logic [DC_W-1:0] c_DC_ONE   = DC_W'(1);
    localparam logic [DC_W-1:0] c_DC_MAX   = DC_W'(DEBOUNCE_SCANS);
    localparam bit              c_ONE_SCAN = (DEBOUNCE_SCANS == 1);

    kp_state_e       r_state;
    logic [DC_W-1:0] r_dc;
    logic [3:0]      r_cand;
    logic [3:0]      r_key_code;
    logic            r_key_valid;
    logic            r_key_down;
    logic            r_overrun;

    frame_class_e    w_class;
    logic [3:0]      w_idx;
    logic            w_same;
    logic            w_dc_hit;
    logic            w_accept;
    logic [3:0]      w_acc_code;

    assign w_class  = classify(i_frame);
    assign w_idx    = index16(i_frame);
    assign w_same   = (w_class == SINGLE) && (w_idx == r_cand);
    assign w_dc_hit = (r_dc + c_DC_ONE) >= c_DC_MAX;

    // Decide whether this scan completes a press, and which code it carries.
    always_comb begin
        w_accept   = 1'b0;
        w_acc_code = r_cand;
        if (i_scan_done) begin
            case (r_state)
                IDLE: begin
                    if ((w_class == SINGLE) && c_ONE_SCAN) begin
                        w_accept   = 1'b1;
                        w_acc_code = w_idx;
                    end
                end
                DEB_PRESS: begin
                    w_accept = w_same && w_dc_hit;
                end
                default: begin
                end
            endcase
        end
    end

    // Debounce FSM plus handshake registers; MULTI frames never start a press
    // but do keep a held key from being released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dc        <= '0;
            r_cand      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (i_scan_done) begin
                case (r_state)
                    IDLE: begin
                        if (w_class == SINGLE) begin
                            r_cand  <= w_idx;
                            r_dc    <= c_DC_ONE;
                            r_state <= c_ONE_SCAN ? HELD : DEB_PRESS;
                        end
                    end
                    DEB_PRESS: begin
                        if (w_same) begin
                            if (w_dc_hit) begin
                                r_state <= HELD;
                            end else begin
                                r_dc <= r_dc + c_DC_ONE;
                            end
                        end else if (w_class == SINGLE) begin
                            r_cand <= w_idx;
                            r_dc   <= c_DC_ONE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (w_class == EMPTY) begin
                            r_dc <= c_DC_ONE;
                            if (c_ONE_SCAN) begin
                                r_state    <= IDLE;
                                r_key_down <= 1'b0;
                            end else begin
                                r_state <= DEB_RELEASE;
                            end
                        end
                    end
                    DEB_RELEASE: begin
                        if (w_class == EMPTY) begin
                            if (w_dc_hit) begin
                                r_state    <= IDLE;
                                r_key_down <= 1'b0;
                            end else begin
                                r_dc <= r_dc + c_DC_ONE;
                            end
                        end else begin
                            r_state <= HELD;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end

            if (w_accept) begin
                r_key_down <= 1'b1;
                if (!r_key_valid || i_key_ack) begin
                    r_key_code  <= w_acc_code;
                    r_key_valid <= 1'b1;
                    r_overrun   <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_key_valid && i_key_ack) begin
                r_key_valid <= 1'b0;
                r_overrun   <= 1'b0;
            end
        end
    end

    assign o_key_code  = r_key_code;
    assign o_key_valid = r_key_valid;
    assign o_key_down  = r_key_down;
    assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: rtl/hex_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : hex_keypad_scan
//  Description : 4x4 hex keypad scanner: column strobe, row sync, snapshot
//                assembly, feeding the debounce/handshake block.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4096,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic       key_ack,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       overrun
);

    localparam int            DW           = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] c_DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    r_rows_s1;
    logic [3:0]    r_rows_s2;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_col;
    logic [3:0]    r_cols;
    logic [15:0]   r_snap;
    logic [15:0]   r_frame;
    logic          r_scan_done;

    logic          w_last;
    logic [15:0]   w_snap_next;

    assign w_last = (r_dwell == c_DWELL_LAST);

    // Two-flop synchronizer for the asynchronous row returns.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rows_s1 <= '0;
            r_rows_s2 <= '0;
        end else begin
            r_rows_s1 <= rows;
            r_rows_s2 <= r_rows_s1;
        end
    end

    // Snapshot with the active column's rows merged in at bits [4*r+c].
    always_comb begin
        w_snap_next = r_snap;
        for (int r = 0; r < NUM_ROWS; r++) begin
            w_snap_next[{2'(r), r_col}] = r_rows_s2[r];
        end
    end

    // Dwell counter, column rotation, snapshot capture and scan-done strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dwell     <= '0;
            r_col       <= '0;
            r_cols      <= 4'b0001;
            r_snap      <= '0;
            r_frame     <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            if (w_last) begin
                r_dwell <= '0;
                r_col   <= r_col + 2'd1;
                r_cols  <= {r_cols[2:0], r_cols[3]};
                if (r_col == 2'd3) begin
                    r_frame     <= w_snap_next;
                    r_snap      <= '0;
                    r_scan_done <= 1'b1;
                end else begin
                    r_snap <= w_snap_next;
                end
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clock),
        .rst         (reset),
        .i_frame     (r_frame),
        .i_scan_done (r_scan_done),
        .i_key_ack   (key_ack),
        .o_key_code  (key_code),
        .o_key_valid (key_valid),
        .o_key_down  (key_down),
        .o_overrun   (overrun)
    );

    assign cols = r_cols;

endmodule
`default_nettype wire

// File: tb/tb_hex_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_keypad_scan
//  Description : Scoreboard bench for hex_keypad_scan (SCAN_DIV=4, DEBOUNCE=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_keypad_scan;

    logic        clock;
    logic        reset;
    logic [3:0]  rows;
    logic        key_ack;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic        overrun;

    logic [15:0] keys;
    logic [3:0]  exp_q[$];
    int          checks;
    int          errors;
    logic        prev_valid;

    hex_keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rows      (rows),
        .key_ack   (key_ack),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad matrix: key 4*r+c closes row r onto column c.
    always_comb begin
        rows = '0;
        for (int r = 0; r < 4; r++) begin
            rows[r] = |(keys[4*r +: 4] & cols);
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every new key_valid presentation pops one expected code.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (key_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_emit: got code %0h expected no emission", key_code);
                end else begin
                    chk("emit_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
                end
            end
            prev_valid <= key_valid;
        end
    end

    // Wait (bounded) for key_valid or key_down to reach a value.
    task automatic wait_for(input bit sel_down, input logic val, input int budget, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if ((sel_down ? key_down : key_valid) == val) begin
                hit = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, hit}, 32'd1);
    endtask

    task automatic ack_pulse();
        @(negedge clock);
        key_ack = 1'b1;
        @(negedge clock);
        key_ack = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        keys    = '0;
        key_ack = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rst_cols",  {28'd0, cols}, 32'h1);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // 1. Asynchronous reset mid-run, then column rotation.
        repeat (7) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_cols",  {28'd0, cols}, 32'h1);
        chk("arst_code",  {28'd0, key_code}, 32'h0);
        chk("arst_valid", {31'd0, key_valid}, 32'd0);
        chk("arst_down",  {31'd0, key_down}, 32'd0);
        chk("arst_ovr",   {31'd0, overrun}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            chk("cols_seq", {28'd0, cols}, 32'd1 << ((k / 4) % 4));
            @(negedge clock);
        end

        // 2. Hold key 9 for 10 scans without ack.
        exp_q.push_back(4'h9);
        keys = 16'h0200;
        wait_for(1'b0, 1'b1, 52, "lat_9");
        chk("down_9", {31'd0, key_down}, 32'd1);
        repeat (130) @(negedge clock);
        chk("held_valid_9", {31'd0, key_valid}, 32'd1);
        keys = '0;
        wait_for(1'b1, 1'b0, 52, "release_9");

        // 3. Ack handshake, and an ignored ack.
        ack_pulse();
        chk("ack_valid", {31'd0, key_valid}, 32'd0);
        chk("ack_code",  {28'd0, key_code}, 32'h9);
        ack_pulse();
        chk("idle_ack_valid", {31'd0, key_valid}, 32'd0);
        chk("idle_ack_code",  {28'd0, key_code}, 32'h9);
        chk("idle_ack_ovr",   {31'd0, overrun}, 32'd0);

        // 4. Key F bouncing on alternate scans never qualifies.
        for (int t = 0; t < 12; t++) begin
            keys = (t % 2 == 0) ? 16'h8000 : 16'h0000;
            repeat (16) @(negedge clock);
            chk("bounce_valid", {31'd0, key_valid}, 32'd0);
            chk("bounce_down",  {31'd0, key_down}, 32'd0);
        end
        keys = '0;
        repeat (32) @(negedge clock);

        // 5. Keys 0 and 5 together are ghost-rejected; 5 alone is accepted.
        keys = 16'h0021;
        repeat (80) @(negedge clock);
        chk("multi_valid", {31'd0, key_valid}, 32'd0);
        chk("multi_down",  {31'd0, key_down}, 32'd0);
        exp_q.push_back(4'h5);
        keys = 16'h0020;
        wait_for(1'b0, 1'b1, 52, "lat_5");
        keys = '0;
        wait_for(1'b1, 1'b0, 52, "release_5");
        ack_pulse();

        // 6. Overrun: A then 3 without ack; 3 is dropped.
        exp_q.push_back(4'hA);
        keys = 16'h0400;
        wait_for(1'b0, 1'b1, 52, "lat_A");
        keys = '0;
        wait_for(1'b1, 1'b0, 52, "release_A");
        keys = 16'h0008;
        wait_for(1'b1, 1'b1, 52, "press_3");
        chk("ovr_set",   {31'd0, overrun}, 32'd1);
        chk("ovr_code",  {28'd0, key_code}, 32'hA);
        chk("ovr_valid", {31'd0, key_valid}, 32'd1);
        keys = '0;
        wait_for(1'b1, 1'b0, 52, "release_3");
        ack_pulse();
        chk("ovr_ack_valid", {31'd0, key_valid}, 32'd0);
        chk("ovr_ack_ovr",   {31'd0, overrun}, 32'd0);

        // Reset during press debounce discards the candidate.
        wait_for(1'b0, 1'b0, 1, "pre_rst_idle");
        begin
            bit aligned;
            aligned = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (cols == 4'b0001) begin
                    aligned = 1'b1;
                    break;
                end
            end
            chk("align_col0", {31'd0, aligned}, 32'd1);
        end
        keys = 16'h0040;
        repeat (22) @(negedge clock);
        #2 reset = 1'b1;
        keys = '0;
        #1;
        chk("deb_rst_valid", {31'd0, key_valid}, 32'd0);
        chk("deb_rst_down",  {31'd0, key_down}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (64) @(negedge clock);
        chk("post_rst_valid", {31'd0, key_valid}, 32'd0);
        chk("post_rst_down",  {31'd0, key_down}, 32'd0);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net in case a wait above is ever unbounded.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
